// File: rtl/i2s_pkg.sv
// Shared I2S definitions: channel encoding used by both the transmitter and
// the receiver, plus the receiver's frame-tracking state type.
package i2s_pkg;

    // Word-select encoding on lrclk.
    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } i2s_ch_t;

    // Receiver framing state: idle until the first left MSB, then alternating.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/i2ss_rx_sync_edge.sv
// Multi-stage synchronizer for a group of asynchronous lines. One line
// (edge_in) additionally gets a registered rising-edge strobe; the other
// lines are only synchronized so they stay aligned with that strobe.
module sync_edge #(
    parameter int W           = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         edge_in,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         rise
);

    // Lane W carries edge_in, lanes W-1..0 carry d.
    logic [W:0] stage_reg [SYNC_STAGES];
    logic [W:0] last_s;
    logic       prev_reg;
    logic       rise_reg;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage captures the raw asynchronous pins.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) stage_reg[gi] <= '0;
                    else      stage_reg[gi] <= {edge_in, d};
                end
            end else begin : g_next
                // Later stages resolve metastability.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) stage_reg[gi] <= '0;
                    else      stage_reg[gi] <= stage_reg[gi-1];
                end
            end
        end
    endgenerate

    assign last_s = stage_reg[SYNC_STAGES-1];
    assign q      = last_s[W-1:0];

    // Registered rising-edge detect on the synchronized edge line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_reg <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            prev_reg <= last_s[W];
            rise_reg <= last_s[W] & ~prev_reg;
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/i2ss_rx.sv
// I2S slave receiver: oversamples the bus in the clk domain, deserializes
// standard I2S (one-bit delayed, MSB first) left/right words of DW bits and
// hands each complete stereo frame out through a one-deep valid/ready holding
// register with a sticky overrun flag.
module i2ss_rx
    import i2s_pkg::*;
#(
    parameter int DW          = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclk,
    input  logic          lrclk,
    input  logic          sdi,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] l_sample,
    output logic [DW-1:0] r_sample,
    output logic          overrun
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] DW_C   = CW'(DW);
    localparam logic [CW-1:0] LAST_C = CW'(DW - 1);

    logic [1:0]    data_s;
    logic          lrclk_s, sdi_s, bit_stb;
    logic          ws_d1_reg, ws_d2_reg;
    logic [CW-1:0] cnt_reg, cnt_next, bit_idx;
    logic [DW-1:0] shift_reg, word_next;
    logic [DW-1:0] l_hold_reg, l_hold_next;
    rx_state_t     state_reg, state_next;
    i2s_ch_t       ch;
    logic          msb, last_bit, committed;
    logic          frame_done;
    logic [DW-1:0] frame_r;
    logic          o_valid_reg, overrun_reg;
    logic [DW-1:0] l_out_reg, r_out_reg;

    sync_edge #(.W(2), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .edge_in (sclk),
        .d       ({sdi, lrclk}),
        .q       (data_s),
        .rise    (bit_stb)
    );

    assign lrclk_s = data_s[0];
    assign sdi_s   = data_s[1];

    // The bit on this strobe belongs to the channel seen one sclk earlier.
    assign ch        = i2s_ch_t'(ws_d1_reg);
    assign msb       = ws_d1_reg ^ ws_d2_reg;
    assign bit_idx   = msb ? '0 : cnt_reg;
    assign last_bit  = (bit_idx == LAST_C);
    assign committed = (cnt_reg == DW_C);

    // Word after inserting the current bit; bits past DW fall off the end.
    always_comb begin
        word_next = msb ? '0 : shift_reg;
        for (int i = 0; i < DW; i++) begin
            if (bit_idx == CW'(DW - 1 - i)) word_next[i] = sdi_s;
        end
        cnt_next = cnt_reg;
        if (msb)                 cnt_next = CW'(1);
        else if (cnt_reg < DW_C) cnt_next = cnt_reg + CW'(1);
    end

    // Bus-side shift state, advanced only on sclk rising edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ws_d1_reg  <= 1'b0;
            ws_d2_reg  <= 1'b0;
            cnt_reg    <= '0;
            shift_reg  <= '0;
            l_hold_reg <= '0;
            state_reg  <= ST_IDLE;
        end else begin
            if (bit_stb) begin
                ws_d2_reg <= ws_d1_reg;
                ws_d1_reg <= lrclk_s;
                cnt_reg   <= cnt_next;
                shift_reg <= word_next;
            end
            l_hold_reg <= l_hold_next;
            state_reg  <= state_next;
        end
    end

    // Framing FSM: decides when a left word is latched and a frame completes.
    // A short slot is closed by the opposite channel's MSB using the word
    // accumulated so far (unreceived LSBs remain zero).
    always_comb begin
        state_next  = state_reg;
        l_hold_next = l_hold_reg;
        frame_done  = 1'b0;
        frame_r     = word_next;
        if (bit_stb) begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (msb && ch == LEFT) state_next = ST_LEFT;
                end
                ST_LEFT: begin
                    if (ch == LEFT && last_bit) l_hold_next = word_next;
                    if (msb && ch == RIGHT) begin
                        if (!committed) l_hold_next = shift_reg;
                        state_next = ST_RIGHT;
                    end
                end
                ST_RIGHT: begin
                    if (ch == RIGHT && last_bit) frame_done = 1'b1;
                    if (msb && ch == LEFT) begin
                        if (!committed) begin
                            frame_done = 1'b1;
                            frame_r    = shift_reg;
                        end
                        state_next = ST_LEFT;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // One-deep output holding register with drop-on-full and sticky overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid_reg <= 1'b0;
            l_out_reg   <= '0;
            r_out_reg   <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (frame_done && (!o_valid_reg || o_ready)) begin
                o_valid_reg <= 1'b1;
                l_out_reg   <= l_hold_next;
                r_out_reg   <= frame_r;
            end else begin
                if (frame_done)             overrun_reg <= 1'b1;
                if (o_valid_reg && o_ready) o_valid_reg <= 1'b0;
            end
        end
    end

    assign o_valid  = o_valid_reg;
    assign l_sample = l_out_reg;
    assign r_sample = r_out_reg;
    assign overrun  = overrun_reg;

endmodule

// File: doc/i2ss_rx.md
# i2ss_rx

I2S slave receiver: the consumer of the bus driven by our I2S master transmitter. It oversamples `sclk`, `lrclk` and serial data in the system clock domain, deserializes standard-I2S frames (left-justified, one-bit delay) into left/right samples of `DW` bits, and presents each complete stereo frame on a valid/ready output with a one-frame holding register and an overrun flag. Used for loopback verification of the transmit path and as the front end for the codec ADC path.

## Interface
- `DW`, 24: sample width in bits per channel; slots may be longer or shorter than `DW`.
- `SYNC_STAGES`, 2: flip-flop stages on each bus input, minimum 2.
- `clk`  in  1  system clock; must be at least 4x `sclk`.
- `rst`  in  1  reset, asynchronous, active-low.
- `sclk`  in  1  I2S bit clock, asynchronous to `clk`.
- `lrclk`  in  1  word select: 0 = left, 1 = right.
- `sdi`  in  1  serial data, MSB first; transmitter changes it on `sclk` falling edges.
- `o_valid`  out  1  stereo frame available.
- `o_ready`  in  1  downstream accepts the frame when `o_valid && o_ready`.
- `l_sample`  out  DW  left sample of the held frame.
- `r_sample`  out  DW  right sample of the held frame.
- `overrun`  out  1  sticky: a completed frame was dropped because the holding register was full.

## Operation
- Synchronize `sclk`, `lrclk`, `sdi` through `SYNC_STAGES` flops. Register `sclk` once more to detect rising edges. All bus state advances only on a detected rising edge (`bit_stb`).
- On each `bit_stb`: `ws_d2 <= ws_d1`, `ws_d1 <= lrclk_s`. The bit sampled at this strobe belongs to channel `ws_d1` (value before update) and is that channel's MSB when `ws_d1 != ws_d2`.
- Bit counter, `$clog2(DW+1)` bits: set to 1 on an MSB strobe, otherwise incremented while below `DW` and saturated at `DW`. Bit k (0 = MSB) is written to shift position `DW-1-k`. Bits beyond `DW` are ignored. The shift register clears to 0 at each MSB, so a short slot leaves its unreceived LSBs at 0.
- FSM, states IDLE, LEFT, RIGHT:
  - IDLE: discards data. Goes to LEFT on the first left MSB strobe.
  - LEFT: on the DW-th bit, or on a right MSB (short slot), latch the word into `l_hold`. On the right MSB, go to RIGHT.
  - RIGHT: on the DW-th bit, or on a left MSB with the word not yet committed, the frame completes with `{l_hold, right word}`. On the left MSB, go to LEFT.
- Frame completion:
  - Holding register empty, or `o_ready` high in the same cycle: load the frame and set `o_valid`.
  - Otherwise: drop the new frame, keep the held frame, set `overrun`.
- `o_valid` clears on a handshake unless a frame loads in the same cycle, in which case it stays high with the new data.
- Consecutive strobes with the same `ws_d1` do not change state. A right MSB seen while in IDLE is ignored.

## Timing
- Reset values: `o_valid`=0, `l_sample`=0, `r_sample`=0, `overrun`=0, FSM=IDLE, all sync and shift flops 0.
- `bit_stb` asserts `SYNC_STAGES+1` clk after the pin `sclk` rise.
- `o_valid` rises 1 clk after the `bit_stb` that completes the frame. Total pin-to-valid latency is `SYNC_STAGES+2` clk from the final `sclk` rise.
- `o_valid` and the data are held stable until the handshake.
- `overrun` sets 1 clk after the dropped completion and clears only on reset.
- Reset asserted mid-frame: everything clears immediately. After release, reception resumes at the next left MSB. The partial frame is never output.
- Reception always starts at a left MSB, so the first partial frame after reset is discarded.

## Structure
- `i2s_pkg`: enum `i2s_ch_t` {LEFT=0, RIGHT=1} shared with the transmitter, and the receiver FSM state typedef.
- One sub-module, `sync_edge`: `SYNC_STAGES` synchronizer plus rising-edge strobe. Instantiate it for `sclk`; `lrclk` and `sdi` use its synchronizer output only.
- The FSM, counter, shift register and output register live in `i2ss_rx`.

## Test plan
- DW=24, 32-bit slots (64 sclk per frame), `o_ready`=1; send L=0xABCDEF, R=0x123456 → one `o_valid` pulse with `l_sample`=0xABCDEF, `r_sample`=0x123456; `overrun`=0.
- DW=24, 16-bit slots; send L=0xBEEF, R=0xCAFE → `l_sample`=0xBEEF00, `r_sample`=0xCAFE00.
- Start the bus mid-right-slot after reset, then send 3 full frames → exactly 3 `o_valid` frames, and the first output is the first full frame.
- Hold `o_ready`=0 across 2 frames (0x111111/0x222222, then 0x333333/0x444444) → the first frame is held unchanged, `overrun`=1; raise `o_ready` → one handshake with 0x111111/0x222222, then `o_valid`=0.
- Assert `rst` low in the middle of the left slot → all outputs 0 within 1 clk; after release, the next full frame 0x0F0F0F/0xF0F0F0 is received correctly with no spurious frame.
- Sweep `clk`/`sclk` ratio 4..16 with random data over 100 frames → every frame is received bit-exact.
